// File: rtl/rm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rm_pkg                                                                     |
// | Shared types, default geometry and width helpers for the ray-march front   |
// | end.                                                                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package rm_pkg;

  localparam int c_display_width  = 320;
  localparam int c_display_height = 240;
  localparam int c_color_bits     = 4;
  localparam int c_sel_bits       = 3;

  function automatic int h_bits(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  function automatic int v_bits(input int height);
    return (height > 1) ? $clog2(height) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DRAIN    = 2'd2
  } dispatch_state_t;

  // Result record at the default geometry; the top builds the same shape from its parameters.
  typedef struct packed {
    logic [h_bits(c_display_width)-1:0]  hcount;
    logic [v_bits(c_display_height)-1:0] vcount;
    logic [c_color_bits-1:0]             color;
  } pix_result_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arbiter                                                                 |
// | Round-robin arbiter; search starts one past the last taken grant.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N        = 4,
  parameter int IDX_BITS = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic                advance,
  output logic [N-1:0]        grant,
  output logic [IDX_BITS-1:0] grant_idx
);

  logic [IDX_BITS-1:0] r_ptr;
  logic [IDX_BITS-1:0] w_idx;
  logic                w_found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_idx     = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = IDX_BITS'((int'(r_ptr) + i) % N);
      if (!w_found && req[w_idx]) begin
        w_found     = 1'b1;
        grant[w_idx] = 1'b1;
        grant_idx   = w_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (advance && |grant) begin
      r_ptr <= (grant_idx == IDX_BITS'(N - 1)) ? '0 : grant_idx + IDX_BITS'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ray_march_dispatcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ray_march_dispatcher                                                       |
// | Raster-order job issue to NUM_CORES march cores and round-robin retire.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ray_march_dispatcher
  import rm_pkg::*;
#(
  parameter  int DISPLAY_WIDTH  = c_display_width,
  parameter  int DISPLAY_HEIGHT = c_display_height,
  parameter  int NUM_CORES      = 4,
  parameter  int COLOR_BITS     = c_color_bits,
  parameter  int SEL_BITS       = c_sel_bits,
  localparam int H_BITS         = h_bits(DISPLAY_WIDTH),
  localparam int V_BITS         = v_bits(DISPLAY_HEIGHT)
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            frame_start_in,
  input  logic [SEL_BITS-1:0]             fractal_sel_in,
  output logic [NUM_CORES-1:0]            job_valid_out,
  input  logic [NUM_CORES-1:0]            job_ready_in,
  output logic [H_BITS-1:0]               job_hcount_out,
  output logic [V_BITS-1:0]               job_vcount_out,
  output logic [SEL_BITS-1:0]             job_sel_out,
  input  logic [NUM_CORES-1:0]            res_valid_in,
  output logic [NUM_CORES-1:0]            res_ready_out,
  input  logic [NUM_CORES*H_BITS-1:0]     res_hcount_in,
  input  logic [NUM_CORES*V_BITS-1:0]     res_vcount_in,
  input  logic [NUM_CORES*COLOR_BITS-1:0] res_color_in,
  output logic [H_BITS-1:0]               hcount_out,
  output logic [V_BITS-1:0]               vcount_out,
  output logic [COLOR_BITS-1:0]           color_out,
  output logic                            valid_out,
  output logic                            new_frame_out,
  output logic                            frame_done_out,
  output logic                            busy_out
);

  localparam int IDX_BITS = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int OUT_BITS = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT + 1);
  localparam logic [H_BITS-1:0] c_h_last = H_BITS'(DISPLAY_WIDTH - 1);
  localparam logic [V_BITS-1:0] c_v_last = V_BITS'(DISPLAY_HEIGHT - 1);

  dispatch_state_t       r_state;
  dispatch_state_t       w_state_next;
  logic [H_BITS-1:0]     r_hcount;
  logic [V_BITS-1:0]     r_vcount;
  logic [SEL_BITS-1:0]   r_sel;
  logic [OUT_BITS-1:0]   r_outstanding;
  logic                  r_first;
  logic [NUM_CORES-1:0]  w_job_valid;
  logic [NUM_CORES-1:0]  w_grant;
  logic [IDX_BITS-1:0]   w_grant_idx;
  logic                  w_start;
  logic                  w_xfer;
  logic                  w_accept;
  logic                  w_last_pixel;
  logic                  w_done;
  logic [H_BITS-1:0]     w_res_h [NUM_CORES];
  logic [V_BITS-1:0]     w_res_v [NUM_CORES];
  logic [COLOR_BITS-1:0] w_res_c [NUM_CORES];

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
    assign w_res_h[g] = res_hcount_in[g*H_BITS +: H_BITS];
    assign w_res_v[g] = res_vcount_in[g*V_BITS +: V_BITS];
    assign w_res_c[g] = res_color_in[g*COLOR_BITS +: COLOR_BITS];
  end

  // Isolate the lowest set ready bit: jobs always favour the lowest-index free core.
  assign w_job_valid  = (r_state == DISPATCH) ? (job_ready_in & (~job_ready_in + NUM_CORES'(1))) : '0;
  assign w_xfer       = |w_job_valid;
  assign w_accept     = |w_grant;
  assign w_start      = (r_state == IDLE) && frame_start_in;
  assign w_last_pixel = (r_hcount == c_h_last) && (r_vcount == c_v_last);

  rr_arbiter #(
    .N        (NUM_CORES),
    .IDX_BITS (IDX_BITS)
  ) u_arb (
    .clk       (clk_in),
    .rst       (rst_in),
    .req       (res_valid_in & {NUM_CORES{~rst_in}}),
    .advance   (w_accept),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  always_comb begin
    w_state_next = r_state;
    w_done       = 1'b0;
    case (r_state)
      IDLE:     if (frame_start_in) w_state_next = DISPATCH;
      DISPATCH: if (w_xfer && w_last_pixel) w_state_next = DRAIN;
      DRAIN: begin
        if ((r_outstanding == '0) && !w_accept) begin
          w_done       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default:  w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_sel         <= '0;
      r_outstanding <= '0;
      r_first       <= 1'b0;
      valid_out     <= 1'b0;
      new_frame_out <= 1'b0;
      hcount_out    <= '0;
      vcount_out    <= '0;
      color_out     <= '0;
    end else begin
      if (w_start) begin
        r_hcount <= '0;
        r_vcount <= '0;
        r_sel    <= fractal_sel_in;
      end else if (w_xfer && !w_last_pixel) begin
        if (r_hcount == c_h_last) begin
          r_hcount <= '0;
          r_vcount <= r_vcount + V_BITS'(1);
        end else begin
          r_hcount <= r_hcount + H_BITS'(1);
        end
      end

      // A stray result with nothing outstanding is still retired; the count floors at zero.
      if (w_xfer && !w_accept) begin
        r_outstanding <= r_outstanding + OUT_BITS'(1);
      end else if (w_accept && !w_xfer && (r_outstanding != '0)) begin
        r_outstanding <= r_outstanding - OUT_BITS'(1);
      end

      if (w_start)       r_first <= 1'b1;
      else if (w_accept) r_first <= 1'b0;

      valid_out     <= w_accept;
      new_frame_out <= w_accept && r_first;
      if (w_accept) begin
        hcount_out <= w_res_h[w_grant_idx];
        vcount_out <= w_res_v[w_grant_idx];
        color_out  <= w_res_c[w_grant_idx];
      end
    end
  end

  assign job_valid_out  = w_job_valid;
  assign res_ready_out  = w_grant;
  assign job_hcount_out = r_hcount;
  assign job_vcount_out = r_vcount;
  assign job_sel_out    = r_sel;
  assign frame_done_out = w_done;
  assign busy_out       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ray_march_dispatcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ray_march_dispatcher                                                    |
// | Randomised bench: modelled march cores plus a frame-level reference model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ray_march_dispatcher;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int NC   = 4;
  localparam int CB   = 4;
  localparam int SB   = 3;
  localparam int HB   = 2;
  localparam int VB   = 1;
  localparam int NPIX = W * H;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic            frame_start_in;
  logic [SB-1:0]   fractal_sel_in;
  logic [NC-1:0]   job_valid_out, job_ready_in, res_valid_in, res_ready_out;
  logic [HB-1:0]   job_hcount_out, hcount_out;
  logic [VB-1:0]   job_vcount_out, vcount_out;
  logic [SB-1:0]   job_sel_out;
  logic [NC*HB-1:0] res_hcount_in;
  logic [NC*VB-1:0] res_vcount_in;
  logic [NC*CB-1:0] res_color_in;
  logic [CB-1:0]   color_out;
  logic            valid_out, new_frame_out, frame_done_out, busy_out;

  ray_march_dispatcher #(
    .DISPLAY_WIDTH (W), .DISPLAY_HEIGHT (H), .NUM_CORES (NC),
    .COLOR_BITS (CB), .SEL_BITS (SB)
  ) dut (
    .clk_in (clk_in), .rst_in (rst_in), .frame_start_in (frame_start_in),
    .fractal_sel_in (fractal_sel_in), .job_valid_out (job_valid_out),
    .job_ready_in (job_ready_in), .job_hcount_out (job_hcount_out),
    .job_vcount_out (job_vcount_out), .job_sel_out (job_sel_out),
    .res_valid_in (res_valid_in), .res_ready_out (res_ready_out),
    .res_hcount_in (res_hcount_in), .res_vcount_in (res_vcount_in),
    .res_color_in (res_color_in), .hcount_out (hcount_out),
    .vcount_out (vcount_out), .color_out (color_out), .valid_out (valid_out),
    .new_frame_out (new_frame_out), .frame_done_out (frame_done_out),
    .busy_out (busy_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int x;
    int y;
    int color;
    int due;
  } job_t;

  job_t q[NC][$];
  int   dut_grants[$];
  int   checks = 0, errors = 0, cyc = 0;

  // Frame-level reference state: phase 0 idle, 1 issuing, 2 draining.
  int m_phase = 0, m_n = 0, m_sel = 0, m_outst = 0, m_first = 0, m_ptr = 0;
  int exp_valid = 0, exp_x = 0, exp_y = 0, exp_color = 0, exp_new = 0;
  int ready_mode = 0, lat_mode = 0, inject = 0, start_req = 0, start_sel = 0;
  int f_valid = 0, f_new = 0, f_done = 0, f_x_first = 0, f_x_last = 0, jobs_sent = 0;
  bit seen[NPIX];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic int colf(input int x, input int y, input int s);
    return (x * 7 + y * 3 + s) % 16;
  endfunction

  task automatic cycle();
    int   jv_idx, win, acc, xf, done_exp, lat;
    job_t j;
    @(negedge clk_in);
    for (int c = 0; c < NC; c++) begin
      case (ready_mode)
        0:       job_ready_in[c] = 1'b1;
        1:       job_ready_in[c] = (c == 1);
        default: job_ready_in[c] = ($urandom_range(0, 3) != 0) && (q[c].size() < 4);
      endcase
      if (q[c].size() > 0 && q[c][0].due <= cyc) begin
        res_valid_in[c]           = 1'b1;
        res_hcount_in[c*HB +: HB] = HB'(q[c][0].x);
        res_vcount_in[c*VB +: VB] = VB'(q[c][0].y);
        res_color_in[c*CB +: CB]  = CB'(q[c][0].color);
      end else begin
        res_valid_in[c]           = 1'b0;
        res_hcount_in[c*HB +: HB] = HB'($urandom);
        res_vcount_in[c*VB +: VB] = VB'($urandom);
        res_color_in[c*CB +: CB]  = CB'($urandom);
      end
    end
    frame_start_in = 1'b0;
    fractal_sel_in = SB'($urandom);
    if (start_req != 0) begin
      frame_start_in = 1'b1;
      fractal_sel_in = SB'(start_sel);
      start_req      = 0;
    end else if (inject != 0 && m_phase == 1 && $urandom_range(0, 5) == 0) begin
      frame_start_in = 1'b1;
      fractal_sel_in = SB'(2);
    end
    #1;
    jv_idx = -1;
    if (m_phase == 1)
      for (int c = 0; c < NC; c++)
        if (job_ready_in[c] && jv_idx < 0) jv_idx = c;
    check("job_valid", job_valid_out, (jv_idx < 0) ? 0 : (1 << jv_idx));
    xf = (jv_idx >= 0);
    if (xf != 0) begin
      check("job_x", job_hcount_out, m_n % W);
      check("job_y", job_vcount_out, m_n / W);
      check("job_sel", job_sel_out, m_sel);
      lat     = (lat_mode == 0) ? 3 : $urandom_range(1, 6);
      j.x     = m_n % W;
      j.y     = m_n / W;
      j.color = colf(j.x, j.y, m_sel);
      j.due   = cyc + lat;
      q[jv_idx].push_back(j);
      if (jobs_sent == 0) f_x_first = cyc;
      f_x_last = cyc;
      jobs_sent++;
    end
    win = -1;
    for (int k = 0; k < NC; k++) begin
      int c;
      c = (m_ptr + k) % NC;
      if (win < 0 && res_valid_in[c]) win = c;
    end
    check("res_ready", res_ready_out, (win < 0) ? 0 : (1 << win));
    for (int c = 0; c < NC; c++)
      if (res_ready_out[c]) dut_grants.push_back(c);
    acc       = (win >= 0);
    exp_valid = acc;
    exp_new   = 0;
    if (acc != 0) begin
      exp_x     = q[win][0].x;
      exp_y     = q[win][0].y;
      exp_color = q[win][0].color;
      exp_new   = m_first;
      void'(q[win].pop_front());
      m_ptr = (win + 1) % NC;
    end
    done_exp = (m_phase == 2 && m_outst == 0 && acc == 0);
    check("frame_done", frame_done_out, done_exp);
    check("busy", busy_out, m_phase != 0);
    check("outstanding", dut.r_outstanding, m_outst);
    if (done_exp != 0) f_done++;
    if (xf != 0 && acc == 0) m_outst++;
    else if (acc != 0 && xf == 0 && m_outst > 0) m_outst--;
    if (m_phase == 0 && frame_start_in) begin
      m_phase = 1;
      m_n     = 0;
      m_sel   = fractal_sel_in;
      m_first = 1;
    end else begin
      if (acc != 0) m_first = 0;
      if (m_phase == 1 && xf != 0) begin
        if (m_n == NPIX - 1) m_phase = 2;
        else m_n++;
      end else if (done_exp != 0) begin
        m_phase = 0;
      end
    end
    @(posedge clk_in);
    #1;
    check("valid_out", valid_out, exp_valid);
    check("new_frame", new_frame_out, (exp_valid != 0) ? exp_new : 0);
    if (exp_valid != 0) begin
      check("out_x", hcount_out, exp_x);
      check("out_y", vcount_out, exp_y);
      check("out_color", color_out, exp_color);
      f_valid++;
      if (exp_new != 0) f_new++;
      seen[exp_x + exp_y * W] = 1'b1;
    end
    cyc++;
  endtask

  task automatic reset_pulse();
    rst_in = 1'b1;
    #1;
    check("rst_valid", valid_out, 0);
    check("rst_new_frame", new_frame_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_done", frame_done_out, 0);
    check("rst_job_valid", job_valid_out, 0);
    check("rst_res_ready", res_ready_out, 0);
    check("rst_hcount", hcount_out, 0);
    check("rst_vcount", vcount_out, 0);
    check("rst_color", color_out, 0);
    check("rst_job_h", job_hcount_out, 0);
    check("rst_job_v", job_vcount_out, 0);
    check("rst_job_sel", job_sel_out, 0);
    check("rst_outstanding", dut.r_outstanding, 0);
    check("rst_state", dut.r_state, 0);
    m_phase = 0; m_n = 0; m_sel = 0; m_outst = 0; m_first = 0; m_ptr = 0;
    exp_valid = 0;
    #1;
    rst_in = 1'b0;
  endtask

  task automatic run_frame(input int sel, input int rmode, input int lmode, input int inj);
    int n, started, nseen;
    ready_mode = rmode; lat_mode = lmode; inject = inj;
    f_valid = 0; f_new = 0; f_done = 0; jobs_sent = 0;
    for (int i = 0; i < NPIX; i++) seen[i] = 1'b0;
    start_req = 1; start_sel = sel;
    started = 0;
    n = 0;
    while (n < 3000) begin
      cycle();
      n++;
      if (m_phase != 0) started = 1;
      if (started != 0 && m_phase == 0) break;
    end
    if (n >= 3000) check("frame_timeout", 1, 0);
    inject = 0;
    nseen = 0;
    for (int i = 0; i < NPIX; i++) nseen += seen[i];
    check("frame_valids", f_valid, NPIX);
    check("frame_new_cnt", f_new, 1);
    check("frame_done_cnt", f_done, 1);
    check("frame_coverage", nseen, NPIX);
  endtask

  initial begin
    int n, inflight;
    job_t j;
    rst_in = 1'b0; frame_start_in = 1'b0; fractal_sel_in = '0;
    job_ready_in = '0; res_valid_in = '0;
    res_hcount_in = '0; res_vcount_in = '0; res_color_in = '0;
    #2;
    reset_pulse();

    // Always-ready cores, 3-cycle latency: all jobs on core0, back to back.
    run_frame(5, 0, 0, 0);
    check("issue_span", f_x_last - f_x_first, NPIX - 1);
    cycle();

    // Only core1 ready.
    run_frame(3, 1, 0, 0);

    // Random readiness, random latency, ignored restarts mid-frame.
    for (int f = 0; f < 6; f++) run_frame($urandom_range(0, 7), 2, 1, 1);

    // Continuous results on every core while idle: grants rotate from core0.
    reset_pulse();
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < 3; k++) begin
        j.x = c; j.y = k % 2; j.color = (c * 5 + k) % 16; j.due = 0;
        q[c].push_back(j);
      end
    dut_grants.delete();
    ready_mode = 0;
    for (int i = 0; i < 14; i++) cycle();
    check("rr_grant_count", dut_grants.size(), 3 * NC);
    for (int i = 0; i < dut_grants.size() && i < 3 * NC; i++)
      check("rr_rotation", dut_grants[i], i % NC);

    // Reset after five jobs; in-flight results later retire as strays.
    ready_mode = 0; lat_mode = 0; jobs_sent = 0;
    start_req = 1; start_sel = 6;
    n = 0;
    while (jobs_sent < 5 && n < 50) begin
      cycle();
      n++;
    end
    check("pre_reset_jobs", jobs_sent, 5);
    reset_pulse();
    inflight = 0;
    for (int c = 0; c < NC; c++) inflight += q[c].size();
    f_valid = 0; f_new = 0;
    n = 0;
    while (n < 50) begin
      cycle();
      n++;
      if (q[0].size() + q[1].size() + q[2].size() + q[3].size() == 0) break;
    end
    cycle();
    check("stray_valids", f_valid, inflight);
    check("stray_new_frame", f_new, 0);
    check("stray_nonzero", inflight > 0, 1);

    // Fresh frame after reset restarts at (0,0).
    run_frame(1, 0, 0, 0);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
